pixel_scan_sequencer: RTL and testbench
=======================================

// Module: pixel_scan_sequencer
// PURPOSE
//  Issues the two-pass pixel read sequence over the image memory and produces the done/reallydone
//  status consumed by the write-enable controller. Pass 1 streams every pixel to the histogram /
//  256-to-8 priority-encoder threshold path; pass 2 re-streams every pixel with a matching output
//  write address for binarized write-back. Sits between top-level start and image RAM / controller.
// PARAMETERS
//  IMG_W   16  image width in pixels
//  IMG_H   16  image height in pixels
//  ADDR_W  8   address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  RD_LAT  1   image RAM read latency in cycles (1..4)
// PORTS
//  clk         in   1       single clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       one-cycle pulse; begins a frame when idle
//  thr_ready   in   1       threshold from priority encoder valid (level)
//  stall       in   1       downstream back-pressure; freezes address issue
//  rd_en       out  1       image RAM read strobe
//  rd_addr     out  ADDR_W  image RAM read address
//  pix_valid   out  1       RAM data valid this cycle (rd_en delayed RD_LAT)
//  pass_id     out  1       0 = pass 1 (histogram), 1 = pass 2 (write-back); aligned with pix_valid
//  wr_addr     out  ADDR_W  output write address, rd_addr delayed RD_LAT
//  done        out  1       level: high while pass 2 is in progress
//  reallydone  out  1       level: high after pass 2 fully drained, until next start
//  busy        out  1       high in every state except IDLE and FINISH
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, address counter 0, delay pipeline cleared.
//  N = IMG_W*IMG_H. States: IDLE, PASS1, DRAIN1, WAIT_THR, PASS2, DRAIN2, FINISH.
//  IDLE/FINISH --start--> PASS1 (reallydone drops the cycle after start is sampled).
//  PASS1: each non-stall cycle rd_en=1, rd_addr=cnt, cnt++; after address N-1 issued -> DRAIN1, cnt=0.
//  DRAIN1: rd_en=0 for RD_LAT cycles so last pass-1 pixel emerges -> WAIT_THR.
//  WAIT_THR: thr_ready sampled only here; if high (incl. already high on entry) -> PASS2 next cycle.
//  PASS2: same issue rule as PASS1; done=1 from first PASS2 cycle; pass_id=1 on emerging pixels.
//  DRAIN2: RD_LAT cycles, done stays 1 until final pix_valid/wr_addr N-1 has been presented.
//  FINISH: done=0, reallydone=1 in the same cycle (never both 1: controller gives done priority,
//   so we clears only once done falls). Holds until start or rst.
//  stall=1: rd_en=0, cnt holds; in-flight reads still emerge (downstream absorbs RD_LAT words).
//  stall ignored outside PASS1/PASS2. start ignored while busy.
//  Throughput: one pixel/cycle without stall; frame = 2N + 2*RD_LAT + WAIT_THR + 2 cycles min.
//  Counter is ADDR_W bits, compared against N-1 (no wrap through unused addresses).
//  N=1: each pass issues one read then drains; must still step through all states.
//  rst mid-frame: immediate return to IDLE, pipeline flushed, no stray pix_valid afterwards.
// STRUCTURE
//  Package scan_pkg: state enum (7 states), localparam N, helper for ADDR_W check.
//  One sub-module: scan_delay_line (RD_LAT-deep shift of {valid, pass_id, addr}, sync clear).
//  Top holds FSM, address counter, drain counter (clog2(RD_LAT+1) bits), done/reallydone regs.
// TESTING
//  4x4, RD_LAT=1, thr_ready tied 1, start at t0 -> rd_addr 0..15 then 0..15, pix_valid 1 cyc later,
//   done rises at first pass-2 read, reallydone rises cycle after wr_addr=15 valid; done&reallydone never 1.
//  thr_ready held 0 for 20 cycles in WAIT_THR -> rd_en=0, done=0 throughout; PASS2 starts 1 cyc after it rises.
//  stall 3 cycles at rd_addr=5 in pass 2 -> address 5 issued once after stall drops, no gaps/duplicates in wr_addr.
//  RD_LAT=3 -> pix_valid trails rd_en by 3, DRAIN states last 3 cycles, wr_addr matches delayed rd_addr.
//  rst asserted mid pass 1 (addr 7) -> next cycle all outputs 0, IDLE; fresh start restarts at addr 0.
//  start pulse during PASS2 -> ignored; second start in FINISH -> reallydone drops, new frame from addr 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and helpers for the two-pass pixel scan sequencer.
// Holds the FSM state encoding and the elaboration-time sizing helpers.
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS1,
    S_DRAIN1,
    S_WAIT_THR,
    S_PASS2,
    S_DRAIN2,
    S_FINISH
  } scan_state_e;

  function automatic int scan_n(input int w, input int h);
    return w * h;
  endfunction

  // True when an ADDR_W-bit counter can address every pixel.
  function automatic bit addr_fits(input int aw, input int n);
    return (n <= (1 << aw));
  endfunction

endpackage

// File: rtl/scan_delay_line.sv
// RD_LAT-deep shift of {valid, pass, addr} that lines issued reads up with RAM data.
// Synchronous clear flushes every in-flight beat so nothing stray emerges after reset.
module scan_delay_line #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_pass,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic              out_pass,
  output logic [ADDR_W-1:0] out_addr
);

  typedef struct packed {
    logic              valid;
    logic              pass;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  beat_t [RD_LAT:1] pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[1] <= '{valid: in_valid, pass: in_pass, addr: in_addr};
      for (int s = 2; s <= RD_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign out_valid = pipe[RD_LAT].valid;
  assign out_pass  = pipe[RD_LAT].pass;
  assign out_addr  = pipe[RD_LAT].addr;

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Two-pass image read sequencer: pass 1 feeds the histogram/threshold path, pass 2
// re-reads for binarized write-back, then reports done/reallydone to the write controller.
module pixel_scan_sequencer
  import scan_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              thr_ready,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  output logic              pass_id,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done,
  output logic              reallydone,
  output logic              busy
);

  localparam int N  = scan_n(IMG_W, IMG_H);
  localparam int DW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);
  localparam logic [DW-1:0]     DLAST = DW'(RD_LAT - 1);

  if (!addr_fits(ADDR_W, N)) begin : g_bad_addr_w
    $error("pixel_scan_sequencer: ADDR_W too small for IMG_W*IMG_H");
  end

  scan_state_e       state, nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DW-1:0]     dcnt;
  logic              issue, last_rd, drain_end, dl_valid, dl_pass;
  logic              done_q, really_q;

  assign issue     = (state == S_PASS1 || state == S_PASS2) && !stall;
  assign last_rd   = (cnt == LAST);
  assign drain_end = (dcnt == DLAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_FINISH: if (start)            nxt = S_PASS1;
      S_PASS1:          if (issue && last_rd) nxt = S_DRAIN1;
      S_DRAIN1:         if (drain_end)        nxt = S_WAIT_THR;
      S_WAIT_THR:       if (thr_ready)        nxt = S_PASS2;
      S_PASS2:          if (issue && last_rd) nxt = S_DRAIN2;
      S_DRAIN2:         if (drain_end)        nxt = S_FINISH;
      default:                                nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b1;
    unique case (state)
      S_IDLE, S_FINISH: busy  = 1'b0;
      S_PASS1, S_PASS2: rd_en = !stall;
      default:          ;
    endcase
  end

  // Counter wraps to 0 at N-1 so pass 2 and the next frame both start at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dcnt <= '0;
    end else begin
      if (issue) cnt <= last_rd ? '0 : cnt + 1'b1;
      if (state == S_DRAIN1 || state == S_DRAIN2) dcnt <= drain_end ? '0 : dcnt + 1'b1;
    end
  end

  // Both flags come from the next state, so done falls exactly as reallydone rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      really_q <= 1'b0;
    end else begin
      done_q   <= (nxt == S_PASS2 || nxt == S_DRAIN2);
      really_q <= (nxt == S_FINISH);
    end
  end

  scan_delay_line #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_pass  (state == S_PASS2),
    .in_addr  (cnt),
    .out_valid(dl_valid),
    .out_pass (dl_pass),
    .out_addr (wr_addr)
  );

  assign rd_addr    = cnt;
  assign pix_valid  = dl_valid;
  assign pass_id    = dl_valid & dl_pass;
  assign done       = done_q;
  assign reallydone = really_q;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Bench: three sequencer variants (4x4/lat1, 4x4/lat3, 1x1/lat2) share random stimulus
// and are compared every cycle against a read-count based frame model.
module tb_pixel_scan_sequencer;

  localparam int NI = 3;
  localparam int NN[NI] = '{16, 16, 1};
  localparam int LL[NI] = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst, start, thr_ready, stall;
  logic       o_en[NI], o_pv[NI], o_pid[NI], o_done[NI], o_rd[NI], o_busy[NI];
  logic [7:0] o_ra[NI], o_wa[NI];

  int checks = 0, failures = 0, cyc = 0;

  // frame model: reads issued so far, drain cycles left, threshold seen
  bit m_in[NI], m_fin[NI], m_thr[NI];
  int m_reads[NI], m_drain[NI], m_first[NI];
  bit h_en[NI][8], h_pass[NI][8];
  int h_addr[NI][8];

  always #5 clk = ~clk;

  pixel_scan_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(8), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .thr_ready(thr_ready), .stall(stall),
    .rd_en(o_en[0]), .rd_addr(o_ra[0]), .pix_valid(o_pv[0]), .pass_id(o_pid[0]),
    .wr_addr(o_wa[0]), .done(o_done[0]), .reallydone(o_rd[0]), .busy(o_busy[0]));

  pixel_scan_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(8), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .thr_ready(thr_ready), .stall(stall),
    .rd_en(o_en[1]), .rd_addr(o_ra[1]), .pix_valid(o_pv[1]), .pass_id(o_pid[1]),
    .wr_addr(o_wa[1]), .done(o_done[1]), .reallydone(o_rd[1]), .busy(o_busy[1]));

  pixel_scan_sequencer #(.IMG_W(1), .IMG_H(1), .ADDR_W(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .thr_ready(thr_ready), .stall(stall),
    .rd_en(o_en[2]), .rd_addr(o_ra[2]), .pix_valid(o_pv[2]), .pass_id(o_pid[2]),
    .wr_addr(o_wa[2]), .done(o_done[2]), .reallydone(o_rd[2]), .busy(o_busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit issuing(input int i);
    return m_in[i] && m_drain[i] == 0 &&
           (m_reads[i] < NN[i] || (m_reads[i] < 2*NN[i] && m_thr[i]));
  endfunction

  task automatic check_all(input bit cmp);
    for (int i = 0; i < NI; i++) begin
      bit e_en, e_pv, e_pid;
      int e_addr, t;
      e_en   = issuing(i) && !stall;
      e_addr = m_reads[i] % NN[i];
      h_en[i][cyc%8]   = e_en;
      h_addr[i][cyc%8] = e_addr;
      h_pass[i][cyc%8] = (m_reads[i] >= NN[i]);
      t     = cyc - LL[i];
      e_pv  = (t >= m_first[i]) && h_en[i][t%8];
      e_pid = e_pv && h_pass[i][t%8];
      if (cmp) begin
        chk($sformatf("rd_en/%0d", i), o_en[i], e_en);
        chk($sformatf("rd_addr/%0d", i), o_ra[i], e_addr);
        chk($sformatf("busy/%0d", i), o_busy[i], m_in[i]);
        chk($sformatf("done/%0d", i), o_done[i], m_in[i] && m_thr[i]);
        chk($sformatf("reallydone/%0d", i), o_rd[i], m_fin[i]);
        chk($sformatf("done_and_rdone/%0d", i), o_done[i] & o_rd[i], 0);
        chk($sformatf("pix_valid/%0d", i), o_pv[i], e_pv);
        chk($sformatf("pass_id/%0d", i), o_pid[i], e_pid);
        if (e_pv) chk($sformatf("wr_addr/%0d", i), o_wa[i], h_addr[i][t%8]);
      end
    end
  endtask

  task automatic model_step(input bit s, input bit st, input bit th, input bit r);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_in[i] = 0; m_fin[i] = 0; m_thr[i] = 0;
        m_reads[i] = 0; m_drain[i] = 0; m_first[i] = cyc + 1;
      end else if (!m_in[i]) begin
        if (s) begin
          m_in[i] = 1; m_fin[i] = 0; m_thr[i] = 0; m_reads[i] = 0; m_drain[i] = 0;
        end
      end else if (issuing(i)) begin
        if (!st) begin
          m_reads[i]++;
          if (m_reads[i] == NN[i] || m_reads[i] == 2*NN[i]) m_drain[i] = LL[i];
        end
      end else if (m_drain[i] > 0) begin
        m_drain[i]--;
        if (m_drain[i] == 0 && m_reads[i] == 2*NN[i]) begin
          m_in[i] = 0; m_fin[i] = 1;
        end
      end else if (th) begin
        m_thr[i] = 1;
      end
    end
  endtask

  task automatic tick(input bit s, input bit st, input bit th, input bit r);
    start = s; stall = st; thr_ready = th; rst = r;
    #1;
    check_all(cyc > 0);
    @(posedge clk);
    model_step(s, st, th, r);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit thr_lvl;
    rst = 1'b1; start = 1'b0; thr_ready = 1'b0; stall = 1'b0;
    for (int i = 0; i < NI; i++) m_first[i] = 0;
    @(negedge clk);
    repeat (3) tick(0, 0, 0, 1);
    for (int i = 0; i < NI; i++) chk($sformatf("wr_addr_reset/%0d", i), o_wa[i], 0);

    // clean frame, threshold already valid
    tick(1, 0, 1, 0);
    repeat (50) tick(0, 0, 1, 0);

    // threshold withheld well past the end of pass 1, plus a start during the frame
    tick(1, 0, 0, 0);
    repeat (45) tick(0, 0, 0, 0);
    repeat (8) tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    repeat (30) tick(0, 0, 1, 0);
    tick(1, 0, 1, 0);
    repeat (4) tick(0, 0, 1, 0);

    // random start/stall/threshold with occasional mid-frame reset
    thr_lvl = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(15) == 0) thr_lvl = ~thr_lvl;
      tick($urandom_range(9) == 0, $urandom_range(3) == 0, thr_lvl,
           $urandom_range(299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
